serial_capture_unit: RTL and testbench
======================================

# serial_capture_unit

Receive-side counterpart of the shift-and-add control: it collects a serial bit stream, one bit per clock over WIDTH consecutive cycles, into a parallel word. It starts on the same level-sensitive Execute handshake and rearms only after Execute is released. It sits beside the register unit, which feeds its Serial_In from the shifting register's output bit. The results go to the hex-display path.

## Interface
- WIDTH, 8: number of bits captured per frame (2..16).
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low; forces the reset state immediately when low.
- Execute  input  1  level start/hold request, same semantics as the multiplier control.
- Serial_In  input  1  serial data bit, LSB first.
- Busy  output  1  high while capturing.
- Done  output  1  high while the captured word is held and Execute is still high.
- Data_Out  output  WIDTH  last completed word.
- Bit_Count  output  clog2(WIDTH+1)  bits captured in the current frame.
- Frame_Count  output  8  completed frames, wraps 255 -> 0.

## Operation
- States: IDLE, SHIFT, HOLD.
- IDLE -> SHIFT when Execute = 1 at a rising edge. Otherwise stay in IDLE.
- SHIFT: at each edge, shift Serial_In into the MSB of an internal shift register, shifting right, so that the first bit received lands in bit 0 after WIDTH shifts.
  - Bit_Count increments on each shift.
  - On the edge that captures bit WIDTH-1:
    - Data_Out <= completed word.
    - Frame_Count increments.
    - Bit_Count resets to 0.
    - State -> HOLD.
- Execute is ignored during SHIFT. Dropping it mid-frame does not abort the frame.
- HOLD: Done = 1. HOLD -> IDLE when Execute = 0 at an edge. The word is never recaptured while Execute stays high.
- Data_Out changes only at frame completion. It holds the previous frame's word throughout a capture.
- Internal shift register: cleared to 0 on IDLE -> SHIFT, so no stale bits leak between frames.
- Outputs are decoded from state only (Moore):
  - Busy = (state == SHIFT).
  - Done = (state == HOLD).
- Reset low, asynchronous, in any state:
  - state = IDLE.
  - Data_Out = 0, Bit_Count = 0, Frame_Count = 0, internal shift register = 0.
  - Busy = 0, Done = 0.
- Reset asserted mid-frame discards the partial word. Data_Out and Frame_Count still read 0 after reset.
- The state encoding must be fully specified. Any illegal encoding returns to IDLE on the next edge.

## Timing
- Execute sampled high in IDLE at edge k:
  - Busy rises after edge k.
  - Serial_In is sampled at edges k+1 through k+WIDTH.
  - Data_Out, Done and Frame_Count update after edge k+WIDTH.
  - Busy falls after edge k+WIDTH.
- Minimum frame period is WIDTH+2 cycles: WIDTH shift cycles, at least one HOLD cycle, and one IDLE cycle.
- Serial_In must be stable around each sampling edge. There is no internal synchronizer; the source is on the same Clk domain.
- Execute low at the last SHIFT edge still completes the frame. The block then spends exactly one cycle in HOLD before returning to IDLE.
- Frame_Count wrap: a completed frame at count 255 yields 0. This is not an error.
- Reset deassertion: the first active edge is the first edge after Reset returns high. Behaviour is normal from that edge.

## Test plan
- Reset, then Execute = 1 with Serial_In sequence 1,0,1,1,0,0,1,0 (WIDTH = 8) -> after the 8th shift edge: Data_Out = 0x4D, Done = 1, Busy = 0, Frame_Count = 1.
- Hold Execute high for 20 cycles after Done -> Data_Out stays 0x4D, Frame_Count stays 1, no second capture. Drop Execute -> IDLE one edge later.
- Start a frame with word 0xFF, drop Execute after the 3rd shift -> capture still completes. Data_Out = 0xFF, Done high for exactly one cycle.
- After a 0x4D frame, start a new frame of all ones and assert Reset at Bit_Count = 5 -> all outputs 0 immediately, without waiting for a clock edge. A following frame of 0x01 captures cleanly as 0x01.
- Run 256 back-to-back frames of word 0xA5 -> Frame_Count reads 255 before the last frame and 0 after it. Data_Out = 0xA5 throughout; the check is that Busy is high for exactly 8 cycles in every frame.
- During a capture of 0x3C, check Data_Out each cycle -> it shows the prior word 0xA5 until the completing edge, then 0x3C.

Source files
------------

// File: rtl/serial_capture_unit.sv
// Serial-to-parallel capture unit: gathers WIDTH LSB-first bits after an Execute handshake
// and holds the completed word until Execute is released.
module serial_capture_unit #(
   parameter  int WIDTH = 8,
   localparam int BCW   = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_execute,
   input  logic             i_serial_in,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_data_out,
   output logic [BCW-1:0]   o_bit_count,
   output logic [7:0]       o_frame_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      HOLD  = 2'b10
   } state_t;

   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_shift;
   logic [WIDTH-1:0]   r_data_out;
   logic [BCW-1:0]     r_bit_count;
   logic [7:0]         r_frame_count;
   logic [WIDTH-1:0]   w_shift_next;
   logic               w_last;

   assign w_shift_next = {i_serial_in, r_shift[WIDTH-1:1]};
   assign w_last       = (r_bit_count == LAST_BIT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // The unused encoding falls through to the default and recovers to IDLE.
   always_comb begin
      w_next_state = IDLE;
      case (r_state)
         IDLE:    w_next_state = i_execute ? SHIFT : IDLE;
         SHIFT:   w_next_state = w_last ? HOLD : SHIFT;
         HOLD:    w_next_state = i_execute ? HOLD : IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift       <= '0;
         r_data_out    <= '0;
         r_bit_count   <= '0;
         r_frame_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_execute) begin
                  r_shift     <= '0;
                  r_bit_count <= '0;
               end
            end
            SHIFT: begin
               r_shift <= w_shift_next;
               if (w_last) begin
                  r_data_out    <= w_shift_next;
                  r_frame_count <= r_frame_count + 8'd1;
                  r_bit_count   <= '0;
               end else begin
                  r_bit_count   <= r_bit_count + BCW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy        = (r_state == SHIFT);
   assign o_done        = (r_state == HOLD);
   assign o_data_out    = r_data_out;
   assign o_bit_count   = r_bit_count;
   assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_serial_capture_unit.sv
// Self-checking bench for serial_capture_unit: directed scenarios plus randomized frames
// checked against a word/frame-count reference model built from the bit stream.
module tb_serial_capture_unit;

   localparam int WIDTH = 8;
   localparam int BCW   = $clog2(WIDTH + 1);

   logic             clk;
   logic             rstN;
   logic             execute;
   logic             serIn;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] dataOut;
   logic [BCW-1:0]   bitCount;
   logic [7:0]       frameCount;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model: last completed word and number of completed frames.
   logic [WIDTH-1:0] expData;
   int               expFrames;

   serial_capture_unit #(.WIDTH(WIDTH)) dut (
      .i_clk         (clk),
      .i_rst_n       (rstN),
      .i_execute     (execute),
      .i_serial_in   (serIn),
      .o_busy        (busy),
      .o_done        (done),
      .o_data_out    (dataOut),
      .o_bit_count   (bitCount),
      .o_frame_count (frameCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] packBits(input bit bits[$]);
      int acc = 0;
      for (int i = 0; i < bits.size(); i++) acc = acc + (int'(bits[i]) * (2 ** i));
      return WIDTH'(acc);
   endfunction

   task automatic applyReset();
      rstN    = 1'b0;
      execute = 1'b0;
      serIn   = 1'b0;
      expData   = '0;
      expFrames = 0;
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge with the unit idle; returns at the negedge after the completing edge.
   task automatic driveFrame(input logic [WIDTH-1:0] w, input int dropAt, output int busyCycles);
      bit bits[$];
      execute = 1'b1;
      @(negedge clk);
      busyCycles = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (busy) busyCycles++;
         serIn = w[i];
         bits.push_back(w[i]);
         if (i == dropAt) execute = 1'b0;
         @(negedge clk);
      end
      expData   = packBits(bits);
      expFrames = expFrames + 1;
   endtask

   task automatic releaseExec();
      execute = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstN = 1'b0; execute = 1'b0; serIn = 1'b0;
      #12;
      testsRun++;
      if ({busy, done, dataOut, bitCount, frameCount} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs: got busy=%b done=%b data=%h bits=%0d frames=%0d, want all 0",
                  busy, done, dataOut, bitCount, frameCount);
      end
      applyReset();
   endtask

   task automatic test_basic_capture();
      int bc;
      driveFrame(8'h4D, -1, bc);
      testsRun++;
      if (dataOut !== 8'h4D || done !== 1'b1 || busy !== 1'b0 || frameCount !== 8'd1) begin
         testsFailed++;
         $display("[TB] FAIL basic_capture: got data=%h done=%b busy=%b frames=%0d, want 4d 1 0 1",
                  dataOut, done, busy, frameCount);
      end
      testsRun++;
      if (bc !== WIDTH) begin
         testsFailed++;
         $display("[TB] FAIL basic_busy_cycles: got %0d, want %0d", bc, WIDTH);
      end
   endtask

   task automatic test_hold_no_recapture();
      int bad = 0;
      for (int c = 0; c < 20; c++) begin
         serIn = 1'($urandom);
         @(negedge clk);
         if (dataOut !== 8'h4D || frameCount !== 8'd1 || done !== 1'b1 || busy !== 1'b0) bad++;
      end
      testsRun++;
      if (bad != 0) begin
         testsFailed++;
         $display("[TB] FAIL hold_stable: %0d bad cycles, last data=%h frames=%0d done=%b, want 4d 1 1",
                  bad, dataOut, frameCount, done);
      end
      releaseExec();
      testsRun++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL hold_release: got done=%b busy=%b, want 0 0", done, busy);
      end
   endtask

   task automatic test_early_release();
      int bc;
      int doneCycles = 0;
      driveFrame(8'hFF, 3, bc);
      for (int c = 0; c < 4; c++) begin
         if (done) doneCycles++;
         @(negedge clk);
      end
      testsRun++;
      if (dataOut !== 8'hFF || frameCount !== 8'(expFrames)) begin
         testsFailed++;
         $display("[TB] FAIL early_release_data: got data=%h frames=%0d, want ff %0d",
                  dataOut, frameCount, expFrames);
      end
      testsRun++;
      if (doneCycles != 1) begin
         testsFailed++;
         $display("[TB] FAIL early_release_done_len: got %0d cycles, want 1", doneCycles);
      end
   endtask

   task automatic test_reset_midframe();
      int bc;
      applyReset();
      driveFrame(8'h4D, -1, bc);
      releaseExec();
      execute = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         serIn = 1'b1;
         @(negedge clk);
      end
      testsRun++;
      if (bitCount !== BCW'(5)) begin
         testsFailed++;
         $display("[TB] FAIL midframe_bitcount: got %0d, want 5", bitCount);
      end
      rstN = 1'b0;
      #1;
      testsRun++;
      if ({busy, done, dataOut, bitCount, frameCount} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL midframe_async_reset: got busy=%b done=%b data=%h bits=%0d frames=%0d, want all 0",
                  busy, done, dataOut, bitCount, frameCount);
      end
      applyReset();
      driveFrame(8'h01, -1, bc);
      testsRun++;
      if (dataOut !== 8'h01 || frameCount !== 8'd1) begin
         testsFailed++;
         $display("[TB] FAIL post_reset_capture: got data=%h frames=%0d, want 01 1", dataOut, frameCount);
      end
      releaseExec();
   endtask

   task automatic test_back_to_back_wrap();
      int bc;
      applyReset();
      for (int f = 0; f < 256; f++) begin
         if (f == 255) begin
            testsRun++;
            if (frameCount !== 8'd255) begin
               testsFailed++;
               $display("[TB] FAIL wrap_before_last: got %0d, want 255", frameCount);
            end
         end
         driveFrame(8'hA5, -1, bc);
         testsRun++;
         if (bc != WIDTH || dataOut !== 8'hA5) begin
            testsFailed++;
            $display("[TB] FAIL b2b_frame%0d: got busy=%0d data=%h, want %0d a5", f, bc, dataOut, WIDTH);
         end
         releaseExec();
      end
      testsRun++;
      if (frameCount !== 8'(expFrames % 256) || frameCount !== 8'd0) begin
         testsFailed++;
         $display("[TB] FAIL wrap_after_last: got %0d, want 0", frameCount);
      end
   endtask

   task automatic test_prior_word();
      logic [WIDTH-1:0] w = 8'h3C;
      int bad = 0;
      execute = 1'b1;
      @(negedge clk);
      for (int i = 0; i < WIDTH; i++) begin
         if (dataOut !== 8'hA5 || bitCount !== BCW'(i)) bad++;
         serIn = w[i];
         @(negedge clk);
      end
      testsRun++;
      if (bad != 0) begin
         testsFailed++;
         $display("[TB] FAIL prior_word_hold: %0d bad cycles, want data a5 with counting bits", bad);
      end
      testsRun++;
      if (dataOut !== 8'h3C || bitCount !== '0 || done !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL prior_word_update: got data=%h bits=%0d done=%b, want 3c 0 1",
                  dataOut, bitCount, done);
      end
      expFrames = expFrames + 1;
      releaseExec();
   endtask

   task automatic test_random();
      int bc;
      logic [WIDTH-1:0] w;
      int dropAt;
      applyReset();
      for (int n = 0; n < 40; n++) begin
         w      = WIDTH'($urandom);
         dropAt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1;
         driveFrame(w, dropAt, bc);
         testsRun++;
         if (dataOut !== expData || frameCount !== 8'(expFrames % 256) || bc != WIDTH || done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL random_frame%0d: got data=%h frames=%0d busy=%0d done=%b, want %h %0d %0d 1",
                     n, dataOut, frameCount, bc, done, expData, expFrames % 256, WIDTH);
         end
         if (dropAt < 0) begin
            for (int h = $urandom_range(0, 3); h > 0; h--) @(negedge clk);
         end
         releaseExec();
         for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic_capture();
      test_hold_no_recapture();
      test_early_release();
      test_reset_midframe();
      test_back_to_back_wrap();
      test_prior_word();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
